// File: rtl/lam_ctrl.sv
// lam_ctrl: load/store access controller between the decoder's lam_* fields
// and a req/ack data-memory port. Builds word address, byte enables and
// lane-rotated store data, extends load data and writes it back.
// Optional feature: define LAM_MISALIGNED_EN to allow misaligned accesses,
// splitting word-crossing ones into two memory beats.
module lam_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lam_new,
    input  logic        lam_rw,
    input  logic [2:0]  lam_type,
    input  logic [4:0]  lam_sel_out,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [4:0]  rf_sel,
    output logic [31:0] rf_data,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [2:0]    type_q, type_d;
    logic [4:0]    sel_q, sel_d;
    logic [29:0]   waddr_q, waddr_d;
    logic [1:0]    off_q, off_d;
    logic [7:0]    be_q, be_d;
    logic          two_q, two_d;
    logic [31:0]   wrot_q, wrot_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   rf_data_q, rf_data_d;
    logic          fault_q, fault_d;
    logic [1:0]    fcode_q, fcode_d;

    // Request decode helpers (from the live inputs, used only in IDLE)
    logic [3:0]  base_be;
    logic [7:0]  be8_in;
    logic [63:0] wrot64;
    logic        illegal, misaligned, crossing;

    // Load data alignment and extension helpers
    logic [31:0] rd_lo;
    logic [63:0] rd64;
    logic [31:0] rd_m;
    logic [31:0] load_ext;
    logic        sgn;

    // State and datapath registers with synchronous reset
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            type_q    <= '0;
            sel_q     <= '0;
            waddr_q   <= '0;
            off_q     <= '0;
            be_q      <= '0;
            two_q     <= 1'b0;
            wrot_q    <= '0;
            lo_q      <= '0;
            rf_data_q <= '0;
            fault_q   <= 1'b0;
            fcode_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            type_q    <= type_d;
            sel_q     <= sel_d;
            waddr_q   <= waddr_d;
            off_q     <= off_d;
            be_q      <= be_d;
            two_q     <= two_d;
            wrot_q    <= wrot_d;
            lo_q      <= lo_d;
            rf_data_q <= rf_data_d;
            fault_q   <= fault_d;
            fcode_q   <= fcode_d;
        end
    end

    // Next-state logic: request decode, handshake, timeout and load merge
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        type_d    = type_q;
        sel_d     = sel_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        be_d      = be_q;
        two_d     = two_q;
        wrot_d    = wrot_q;
        lo_d      = lo_q;
        rf_data_d = rf_data_q;
        fault_d   = 1'b0;
        fcode_d   = 2'b00;

        // Enable pattern for the access size, shifted into an 8-lane window
        case (lam_type[1:0])
            2'b00:   base_be = 4'b0001;
            2'b01:   base_be = 4'b0011;
            default: base_be = 4'b1111;
        endcase
        be8_in  = {4'b0000, base_be} << addr[1:0];
        wrot64  = {wdata, wdata} << {addr[1:0], 3'b000};
        illegal = (lam_rw & lam_type[2]) | (lam_type[1:0] == 2'b11) |
                  (lam_type == 3'b110);
`ifdef LAM_MISALIGNED_EN
        misaligned = 1'b0;
        crossing   = |be8_in[7:4];
`else
        misaligned = (|be8_in[7:4]) | ((lam_type[1:0] == 2'b01) & addr[0]);
        crossing   = 1'b0;
`endif

        // Rotate the (possibly two-word) read data down to lane 0 and extend
        rd_lo = (state_q == REQ2) ? lo_q : mem_rdata;
        rd64  = {mem_rdata, rd_lo} >> {off_q, 3'b000};
        rd_m  = rd64[31:0];
        sgn   = ~type_q[2];
        case (type_q[1:0])
            2'b00:   load_ext = {{24{sgn & rd_m[7]}}, rd_m[7:0]};
            2'b01:   load_ext = {{16{sgn & rd_m[15]}}, rd_m[15:0]};
            default: load_ext = rd_m;
        endcase

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (lam_new) begin
                    rw_d    = lam_rw;
                    type_d  = lam_type;
                    sel_d   = lam_sel_out;
                    waddr_d = addr[31:2];
                    off_d   = addr[1:0];
                    be_d    = be8_in;
                    two_d   = crossing;
                    wrot_d  = wrot64[63:32];
                    if (illegal) begin
                        fault_d = 1'b1;
                        fcode_d = FC_ILLEGAL;
                    end else if (misaligned) begin
                        fault_d = 1'b1;
                        fcode_d = FC_MISALIGN;
                    end else begin
                        state_d = REQ1;
                    end
                end
            end
            REQ1, REQ2: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if ((state_q == REQ1) && two_q) begin
                        lo_d    = mem_rdata;
                        state_d = REQ2;
                    end else begin
                        rf_data_d = load_ext;
                        state_d   = DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    fcode_d = FC_TIMEOUT;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: memory port driven only while a beat is outstanding
    always_comb begin
        busy       = (state_q != IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        rf_we      = 1'b0;
        rf_sel     = '0;
        rf_data    = '0;
        fault      = fault_q;
        fault_code = fcode_q;
        case (state_q)
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = rw_q;
                mem_addr  = {waddr_q, 2'b00};
                mem_be    = be_q[3:0];
                mem_wdata = wrot_q;
            end
            REQ2: begin
                mem_req   = 1'b1;
                mem_we    = rw_q;
                mem_addr  = {waddr_q + 30'd1, 2'b00};
                mem_be    = be_q[7:4];
                mem_wdata = wrot_q;
            end
            DONE: begin
                if (!rw_q && (sel_q != 5'd0)) begin
                    rf_we   = 1'b1;
                    rf_sel  = sel_q;
                    rf_data = rf_data_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lam_ctrl.sv
// Self-checking bench for lam_ctrl: a table of single-beat accesses and
// decode faults, plus directed sequences for wait states, timeout, reset
// during an access and (with LAM_MISALIGNED_EN) the two-beat split.
module tb_lam_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        lam_new;
    logic        lam_rw;
    logic [2:0]  lam_type;
    logic [4:0]  lam_sel_out;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rf_we;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic        fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lam_ctrl #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .lam_new     (lam_new),
        .lam_rw      (lam_rw),
        .lam_type    (lam_type),
        .lam_sel_out (lam_sel_out),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .rf_we       (rf_we),
        .rf_sel      (rf_sel),
        .rf_data     (rf_data),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    typedef struct {
        logic        rw;
        logic [2:0]  typ;
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  fcode;    // non-zero: expect a decode fault
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        rfwe;
        logic [31:0] rfdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rw, input logic [2:0] typ, input logic [4:0] sel,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input logic [1:0] fcode, input logic [31:0] maddr, input logic [3:0] be,
                       input logic [31:0] mwdata, input logic rfwe, input logic [31:0] rfdata);
        vec_t v;
        v = '{rw, typ, sel, a, wd, rd, fcode, maddr, be, mwdata, rfwe, rfdata};
        vecs.push_back(v);
    endtask

    // Present one request at the next falling edge; returns after edge N + 1
    task automatic issue(input logic rw, input logic [2:0] typ, input logic [4:0] sel,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        lam_new     = 1'b1;
        lam_rw      = rw;
        lam_type    = typ;
        lam_sel_out = sel;
        addr        = a;
        wdata       = wd;
        @(posedge clk);
        #1;
        lam_new = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " mem_req"},    32'(mem_req),    32'd0);
        check({tag, " mem_we"},     32'(mem_we),     32'd0);
        check({tag, " mem_addr"},   mem_addr,        32'd0);
        check({tag, " mem_be"},     32'(mem_be),     32'd0);
        check({tag, " mem_wdata"},  mem_wdata,       32'd0);
        check({tag, " rf_we"},      32'(rf_we),      32'd0);
        check({tag, " rf_data"},    rf_data,         32'd0);
        check({tag, " fault"},      32'(fault),      32'd0);
        check({tag, " fault_code"}, 32'(fault_code), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int req_cycles;
        string t;

        rst = 1'b1; lam_new = 1'b0; lam_rw = 1'b0; lam_type = 3'b000;
        lam_sel_out = 5'd0; addr = 32'd0; wdata = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;

        //   rw    type    sel   addr          wdata         rdata         fc     maddr         be       mwdata        rfwe  rfdata
        add(1'b0, 3'b010, 5'd5, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF);
        add(1'b0, 3'b000, 5'd6, 32'h0000_0103, 32'h0,        32'h8012_3456, 2'b00, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80);
        add(1'b0, 3'b100, 5'd6, 32'h0000_0103, 32'h0,        32'h8012_3456, 2'b00, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'h0000_0080);
        add(1'b1, 3'b001, 5'd0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        2'b00, 32'h0000_0200, 4'b1100, 32'hABCD_1234, 1'b0, 32'h0);
        add(1'b0, 3'b001, 5'd7, 32'h0000_0102, 32'h0,        32'h8001_7777, 2'b00, 32'h0000_0100, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001);
        add(1'b0, 3'b101, 5'd8, 32'h0000_0100, 32'h0,        32'h1234_F00D, 2'b00, 32'h0000_0100, 4'b0011, 32'h0,        1'b1, 32'h0000_F00D);
        add(1'b1, 3'b000, 5'd3, 32'h0000_0301, 32'h0000_00A5, 32'h0,        2'b00, 32'h0000_0300, 4'b0010, 32'h0000_A500, 1'b0, 32'h0);
        add(1'b1, 3'b010, 5'd4, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        2'b00, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);
        add(1'b0, 3'b010, 5'd0, 32'h0000_0104, 32'h0,        32'h5555_AAAA, 2'b00, 32'h0000_0104, 4'b1111, 32'h0,        1'b0, 32'h0);
        add(1'b0, 3'b000, 5'd9, 32'h0000_0102, 32'h0,        32'h007F_0000, 2'b00, 32'h0000_0100, 4'b0100, 32'h0,        1'b1, 32'h0000_007F);
        add(1'b1, 3'b100, 5'd1, 32'h0000_0100, 32'h1,        32'h0,        2'b10, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0);
        add(1'b0, 3'b011, 5'd1, 32'h0000_0100, 32'h0,        32'h0,        2'b10, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0);
        add(1'b0, 3'b110, 5'd1, 32'h0000_0100, 32'h0,        32'h0,        2'b10, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0);
`ifndef LAM_MISALIGNED_EN
        add(1'b0, 3'b010, 5'd2, 32'h0000_0101, 32'h0,        32'h0,        2'b01, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0);
        add(1'b0, 3'b001, 5'd2, 32'h0000_0101, 32'h0,        32'h0,        2'b01, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0);
        add(1'b1, 3'b001, 5'd2, 32'h0000_0203, 32'h0,        32'h0,        2'b01, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table of single-beat accesses and decode faults (ack on first cycle)
        for (int i = 0; i < vecs.size(); i++) begin
            t = $sformatf("vec%0d", i);
            issue(vecs[i].rw, vecs[i].typ, vecs[i].sel, vecs[i].a, vecs[i].wd);
            if (vecs[i].fcode != 2'b00) begin
                check({t, " fault"},      32'(fault),      32'd1);
                check({t, " fault_code"}, 32'(fault_code), 32'(vecs[i].fcode));
                check({t, " mem_req"},    32'(mem_req),    32'd0);
                check({t, " busy"},       32'(busy),       32'd0);
                @(posedge clk);
                #1;
                check({t, " fault pulse"}, 32'(fault), 32'd0);
            end else begin
                check({t, " fault"},    32'(fault),   32'd0);
                check({t, " busy"},     32'(busy),    32'd1);
                check({t, " mem_req"},  32'(mem_req), 32'd1);
                check({t, " mem_we"},   32'(mem_we),  32'(vecs[i].rw));
                check({t, " mem_addr"}, mem_addr,     vecs[i].maddr);
                check({t, " mem_be"},   32'(mem_be),  32'(vecs[i].be));
                if (vecs[i].rw)
                    check({t, " mem_wdata"}, mem_wdata, vecs[i].mwdata);
                mem_ack   = 1'b1;
                mem_rdata = vecs[i].rd;
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                check({t, " done mem_req"}, 32'(mem_req), 32'd0);
                check({t, " done busy"},    32'(busy),    32'd1);
                check({t, " rf_we"},        32'(rf_we),   32'(vecs[i].rfwe));
                if (vecs[i].rfwe) begin
                    check({t, " rf_sel"},  32'(rf_sel), 32'(vecs[i].sel));
                    check({t, " rf_data"}, rf_data,     vecs[i].rfdata);
                end
                @(posedge clk);
                #1;
                check({t, " idle busy"}, 32'(busy),  32'd0);
                check({t, " idle rf_we"}, 32'(rf_we), 32'd0);
            end
        end

        // Wait states: request held stable, new requests ignored while busy
        issue(1'b0, 3'b010, 5'd9, 32'h0000_0208, 32'h0);
        lam_new = 1'b1;
        addr    = 32'h0000_0500;
        for (int k = 0; k < 3; k++) begin
            check("wait mem_req",  32'(mem_req), 32'd1);
            check("wait mem_addr", mem_addr,     32'h0000_0208);
            @(posedge clk);
            #1;
        end
        lam_new   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("wait rf_we",   32'(rf_we), 32'd1);
        check("wait rf_data", rf_data,    32'h0BAD_F00D);
        @(posedge clk);
        #1;
        check("wait idle busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("wait no restart", 32'(mem_req), 32'd0);

        // Timeout: mem_req high for exactly TIMEOUT cycles, then fault 11
        issue(1'b0, 3'b010, 5'd3, 32'h0000_0100, 32'h0);
        req_cycles = 0;
        cyc = 0;
        while (mem_req && cyc < 40) begin
            req_cycles++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check("timeout req cycles", 32'(req_cycles), 32'd16);
        check("timeout fault",      32'(fault),      32'd1);
        check("timeout fault_code", 32'(fault_code), 32'd3);
        check("timeout rf_we",      32'(rf_we),      32'd0);
        check("timeout busy",       32'(busy),       32'd0);
        @(posedge clk);
        #1;
        check("timeout after fault", 32'(fault), 32'd0);
        check("timeout after rf_we", 32'(rf_we), 32'd0);

        // Reset during REQ1
        issue(1'b1, 3'b010, 5'd4, 32'h0000_0300, 32'h1234_5678);
        check("rst pre mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("rst mid");
        @(posedge clk);
        #1;
        check("rst post busy",  32'(busy),  32'd0);
        check("rst post fault", 32'(fault), 32'd0);

`ifdef LAM_MISALIGNED_EN
        // Word-crossing load: two beats, merged result
        issue(1'b0, 3'b010, 5'd12, 32'h0000_0101, 32'h0);
        check("split b1 mem_addr", mem_addr,     32'h0000_0100);
        check("split b1 mem_be",   32'(mem_be),  32'b1110);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3322_11AA;
        @(posedge clk);
        #1;
        mem_rdata = 32'hBBCC_DD44;
        check("split b2 mem_req",  32'(mem_req), 32'd1);
        check("split b2 mem_addr", mem_addr,     32'h0000_0104);
        check("split b2 mem_be",   32'(mem_be),  32'b0001);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("split rf_we",   32'(rf_we), 32'd1);
        check("split rf_data", rf_data,    32'h4433_2211);
        @(posedge clk);
        #1;
        check("split idle busy", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
